// File: rtl/uart_cmd_sequencer_if.sv
// Signals between the UART receiver, the command sequencer and the command consumer.
// The sequencer connects through the slave modport; stimulus or upstream logic uses master.
interface uart_cmd_sequencer_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
  logic        cmd_vld;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_ack;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output rx_rdy, rx_data, cmd_ack,
    input  clr_rdy, cmd_vld, cmd_op, cmd_data, err, err_code
  );

  modport slave (
    input  rx_rdy, rx_data, cmd_ack,
    output clr_rdy, cmd_vld, cmd_op, cmd_data, err, err_code
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Turns the UART byte stream into header-framed 3-byte commands with an inter-byte timeout.
// Define CMD_CHKSUM_EN to require a trailing XOR check byte (5-byte frames).
module uart_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
  input logic                 clk,
  input logic                 rst,
  uart_cmd_sequencer_if.slave bus
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StHdr,
    StOp,
    StDhi,
    StDlo,
`ifdef CMD_CHKSUM_EN
    StChk,
`endif
    StHold
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      op_q;
  logic [15:0]     data_q;
  logic            vld_q;
  logic            err_q;
  logic [1:0]      err_code_q;

  logic accept;
  logic in_frame;

  always_comb begin
    accept   = bus.rx_rdy && (state_q != StHold) && !rst;
    in_frame = (state_q != StHdr) && (state_q != StHold);
  end

`ifdef CMD_CHKSUM_EN
  logic chk_ok;
  always_comb chk_ok = (op_q ^ data_q[15:8] ^ data_q[7:0] ^ bus.rx_data) == 8'h00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHdr;
      cnt_q      <= '0;
      op_q       <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      err_q <= 1'b0;
      cnt_q <= (accept || !in_frame) ? '0 : cnt_q + 1'b1;
      // An accept landing on the timeout cycle wins over the timeout.
      if (accept) begin
        unique case (state_q)
          StHdr: if (bus.rx_data == HDR_BYTE) state_q <= StOp;
          StOp: begin
            op_q    <= bus.rx_data;
            state_q <= StDhi;
          end
          StDhi: begin
            data_q[15:8] <= bus.rx_data;
            state_q      <= StDlo;
          end
`ifdef CMD_CHKSUM_EN
          StDlo: begin
            data_q[7:0] <= bus.rx_data;
            state_q     <= StChk;
          end
          StChk: begin
            if (chk_ok) begin
              state_q <= StHold;
              vld_q   <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
              state_q    <= StHdr;
            end
          end
`else
          StDlo: begin
            data_q[7:0] <= bus.rx_data;
            state_q     <= StHold;
            vld_q       <= 1'b1;
          end
`endif
          default: state_q <= StHdr;
        endcase
      end else if (in_frame && (cnt_q == CntMax)) begin
        err_q      <= 1'b1;
        err_code_q <= 2'b01;
        state_q    <= StHdr;
      end else if ((state_q == StHold) && bus.cmd_ack) begin
        state_q <= StHdr;
        vld_q   <= 1'b0;
      end
    end
  end

  assign bus.clr_rdy  = accept;
  assign bus.cmd_vld  = vld_q;
  assign bus.cmd_op   = op_q;
  assign bus.cmd_data = data_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: a table of frames plus hand-written timeout,
// hold/ack and reset sequences. Works with or without CMD_CHKSUM_EN.
module tb_uart_cmd_sequencer;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_sequencer_if bus ();

  uart_cmd_sequencer #(
    .TIMEOUT_CYC (TO),
    .HDR_BYTE    (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int clr_pulses = 0;
  int err_pulses = 0;

  always @(posedge clk) if (bus.clr_rdy) clr_pulses <= clr_pulses + 1;
  always @(negedge clk) if (bus.err) err_pulses <= err_pulses + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] bytes;  // left-aligned, first byte in [63:56]
    int          n;
    logic        vld;
    logic [7:0]  op;
    logic [15:0] data;
    int          errs;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present a byte and hold rx_rdy until the DUT consumes it, then drop it like the receiver.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    while (n < 50) begin
      #1;
      if (bus.clr_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic send_frame(input string tag, input logic [63:0] bytes, input int n);
    bit ok;
    bit all_ok;
    int c0;
    c0     = clr_pulses;
    all_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[63-8*i -: 8], ok);
      all_ok &= ok;
    end
    chk({tag, "_accepted"}, 32'(all_ok), 32'd1);
    chk({tag, "_clr_pulses"}, 32'(clr_pulses - c0), 32'(n));
  endtask

  // Entered just after the edge that accepted the final byte.
  task automatic check_cmd(input string tag, input int e0, input logic vld, input logic [7:0] op,
                           input logic [15:0] data, input int errs, input logic [1:0] code);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(bus.cmd_vld), 32'(vld));
    if (vld) begin
      chk({tag, "_op"}, 32'(bus.cmd_op), 32'(op));
      chk({tag, "_data"}, 32'(bus.cmd_data), 32'(data));
    end
    repeat (2) @(negedge clk);
    chk({tag, "_err_pulses"}, 32'(err_pulses - e0), 32'(errs));
    if (errs != 0) chk({tag, "_err_code"}, 32'(bus.err_code), 32'(code));
    if (vld) begin
      bus.cmd_ack = 1'b1;
      @(negedge clk);
      bus.cmd_ack = 1'b0;
      chk({tag, "_vld_after_ack"}, 32'(bus.cmd_vld), 32'd0);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int e0;
    e0 = err_pulses;
    send_frame(tag, v.bytes, v.n);
    check_cmd(tag, e0, v.vld, v.op, v.data, v.errs, v.code);
  endtask

  initial begin
    vec_t basic;
    logic [63:0] tail;
    int tail_n;
    int e0, c0, first, bad, clr_bad;

`ifdef CMD_CHKSUM_EN
    basic  = '{64'hA512345670_000000, 5, 1'b1, 8'h12, 16'h3456, 0, 2'b00};
    tail   = 64'h12345670_00000000;
    tail_n = 4;
    vecs.push_back(basic);
    vecs.push_back('{64'h00FFA501020300_00, 7, 1'b1, 8'h01, 16'h0203, 0, 2'b00});
    vecs.push_back('{64'hA5ABCDEF89_000000, 5, 1'b1, 8'hAB, 16'hCDEF, 0, 2'b00});
    vecs.push_back('{64'hA5A5A5A5A5_000000, 5, 1'b1, 8'hA5, 16'hA5A5, 0, 2'b00});
    vecs.push_back('{64'hA512345671_000000, 5, 1'b0, 8'h00, 16'h0000, 1, 2'b10});
    vecs.push_back(basic);
`else
    basic  = '{64'hA5123456_00000000, 4, 1'b1, 8'h12, 16'h3456, 0, 2'b00};
    tail   = 64'h123456_0000000000;
    tail_n = 3;
    vecs.push_back(basic);
    vecs.push_back('{64'h00FFA5010203_0000, 6, 1'b1, 8'h01, 16'h0203, 0, 2'b00});
    vecs.push_back('{64'hA5ABCDEF_00000000, 4, 1'b1, 8'hAB, 16'hCDEF, 0, 2'b00});
    vecs.push_back('{64'hA5A5A5A5_00000000, 4, 1'b1, 8'hA5, 16'hA5A5, 0, 2'b00});
`endif

    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    bus.cmd_ack = 1'b0;

    // Reset state; an ack with nothing held must be ignored.
    #1;
    chk("rst_vld", 32'(bus.cmd_vld), 32'd0);
    chk("rst_op", 32'(bus.cmd_op), 32'd0);
    chk("rst_data", 32'(bus.cmd_data), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_code", 32'(bus.err_code), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.cmd_ack = 1'b1;
    @(negedge clk);
    bus.cmd_ack = 1'b0;
    chk("idle_ack_vld", 32'(bus.cmd_vld), 32'd0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Timeout: A5,12 then silence; err must rise exactly TO cycles after the 0x12 accept.
    send_frame("tmo", 64'hA512_000000000000, 2);
    e0    = err_pulses;
    first = 0;
    for (int k = 1; k <= TO + 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.err && first == 0) first = k;
    end
    chk("tmo_cycle", 32'(first), 32'(TO));
    chk("tmo_pulses", 32'(err_pulses - e0), 32'd1);
    chk("tmo_code_held", 32'(bus.err_code), 32'b01);
    run_vec("after_tmo", basic);

    // Hold: command parked with a byte pending for 100 cycles.
    e0 = err_pulses;
    send_frame("hold", basic.bytes, basic.n);
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'hA5;
    c0      = clr_pulses;
    bad     = 0;
    clr_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!bus.cmd_vld || bus.cmd_op != 8'h12 || bus.cmd_data != 16'h3456) bad++;
      if (bus.clr_rdy) clr_bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    chk("hold_no_clr", 32'(clr_bad), 32'd0);
    chk("hold_no_pulse", 32'(clr_pulses - c0), 32'd0);
    bus.cmd_ack = 1'b1;
    @(negedge clk);
    bus.cmd_ack = 1'b0;
    chk("ack_vld_low", 32'(bus.cmd_vld), 32'd0);
    chk("ack_next_clr", 32'(bus.clr_rdy), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_rdy = 1'b0;
    e0 = err_pulses;
    send_frame("hold_tail", tail, tail_n);
    check_cmd("hold_tail", e0, 1'b1, 8'h12, 16'h3456, 0, 2'b00);

    // Reset mid-frame with a byte pending; err_code still holds 01 from the timeout.
    send_frame("rstmid", 64'hA512_000000000000, 2);
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'hA5;
    rst = 1'b1;
    #1;
    chk("rstmid_clr", 32'(bus.clr_rdy), 32'd0);
    chk("rstmid_vld", 32'(bus.cmd_vld), 32'd0);
    chk("rstmid_op", 32'(bus.cmd_op), 32'd0);
    chk("rstmid_data", 32'(bus.cmd_data), 32'd0);
    chk("rstmid_err", 32'(bus.err), 32'd0);
    chk("rstmid_code", 32'(bus.err_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstrel_clr", 32'(bus.clr_rdy), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_rdy = 1'b0;
    e0 = err_pulses;
    send_frame("rst_tail", tail, tail_n);
    check_cmd("rst_tail", e0, 1'b1, 8'h12, 16'h3456, 0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Frame sequencer that sits directly behind the UART receiver and turns its byte stream into validated 3-byte commands for the segway control logic. It consumes bytes through the receiver's `rdy`/`clr_rdy` handshake and hunts for a 0xA5 header. It then collects opcode, data-high and data-low bytes (plus an optional XOR check byte), enforces an inter-byte timeout, and presents the finished command on a valid/ack interface.

## Interface
- `TIMEOUT_CYC`, default 1_000_000: maximum clk cycles allowed between consecutive bytes inside a frame (20 ms at 50 MHz); must be ≥ 2.
- `HDR_BYTE`, default 8'hA5: frame header value.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `rx_rdy` input 1: byte-ready flag from the UART receiver.
- `rx_data` input 8: received byte; valid while `rx_rdy`=1.
- `clr_rdy` output 1: one-cycle consume strobe back to the receiver.
- `cmd_vld` output 1: command available, held until acked.
- `cmd_op` output 8: command opcode.
- `cmd_data` output 16: command operand, {data-high, data-low}.
- `cmd_ack` input 1: consumer accepts the command.
- `err` output 1: one-cycle error pulse.
- `err_code` output 2: error cause, valid with `err`; 2'b01 timeout, 2'b10 checksum.

## Operation
- States: HDR, OP, DHI, DLO, CHK (only present with `CMD_CHKSUM_EN`), HOLD.
- Accept condition: `rx_rdy`=1, state ≠ HOLD, `rst`=0. On accept, `clr_rdy`=1 in the same cycle (combinational from state and `rx_rdy`) and the byte is processed at that clock edge. The receiver drops `rdy` one cycle later, so no byte is consumed twice.
- HDR: an accepted byte equal to `HDR_BYTE` moves to OP; any other byte is consumed and discarded, with no error.
- OP → DHI → DLO: each accepted byte is stored in `cmd_op`, `cmd_data[15:8]` and `cmd_data[7:0]` respectively.
- DLO accept: move to HOLD without the macro, or to CHK with it.
- CHK accept: if `op ^ dhi ^ dlo ^ chk == 8'h00`, go to HOLD. Otherwise pulse `err` with `err_code`=2'b10 and go to HDR, with `cmd_vld` never asserted.
- HOLD: `cmd_vld`=1 and no bytes are consumed (`clr_rdy`=0); `rx_rdy` is left pending. `cmd_ack`=1 while in HOLD returns the FSM to HDR.
- Timeout counter:
  - Cleared on every accept and whenever the state is HDR or HOLD.
  - Otherwise increments by 1 per cycle; width is `$clog2(TIMEOUT_CYC)`.
  - When it equals `TIMEOUT_CYC-1` in OP/DHI/DLO/CHK with no accept that cycle: pulse `err` with `err_code`=2'b01, go to HDR and discard the partial frame.
  - An accept in the same cycle as the timeout takes priority, and no error is raised.
- `cmd_op`/`cmd_data` registers are only written on accept, so they are stable throughout HOLD.
- `err_code` holds its last value between pulses.

## Timing
- Reset values: state HDR, `cmd_vld`=0, `cmd_op`=0, `cmd_data`=0, `err`=0, `err_code`=0, timeout counter 0. `clr_rdy` is forced to 0 while `rst`=1.
- Reset mid-frame: the partial frame is lost and any pending `rx_rdy` is consumed after reset releases.
- Latency: final byte (DLO, or CHK with the macro) accepted at edge N → `cmd_vld`=1 from edge N (registered state), i.e. visible in cycle N+1.
- `cmd_ack` sampled high at edge M while `cmd_vld`=1 → `cmd_vld`=0 after edge M. The earliest next accept is the cycle following M.
- `cmd_ack` while `cmd_vld`=0 is ignored.
- `err` is registered, high for exactly one cycle after the offending edge.
- Throughput: at most one byte per 2 cycles (imposed by the receiver handshake); no limit internally.

## Configuration
- `CMD_CHKSUM_EN` defined: frames are 5 bytes (header, op, dhi, dlo, chk). The CHK state is present and checksum errors are reported.
- `CMD_CHKSUM_EN` undefined: frames are 4 bytes and there is no CHK state. `err_code` 2'b10 is never produced.

## Test plan
- Bytes A5,12,34,56 (plus chk 70 when enabled) → `cmd_vld`=1, `cmd_op`=8'h12, `cmd_data`=16'h3456. Each byte sees exactly one `clr_rdy` pulse.
- Garbage 00,FF then A5,01,02,03(,00) → the two garbage bytes are consumed silently, then command op=01, data=0203 is delivered with no `err`.
- With `CMD_CHKSUM_EN`: A5,12,34,56,71 → `err`=1 for one cycle with `err_code`=2'b10, no `cmd_vld`, state HDR.
- `TIMEOUT_CYC`=16: A5,12, then idle → `err` pulse with `err_code`=2'b01 exactly 16 cycles after the 0x12 accept. A following full frame decodes correctly.
- Hold `cmd_ack`=0 for 100 cycles with a new byte pending → `cmd_vld` and outputs stay stable and `clr_rdy` stays 0. Asserting `cmd_ack` drops `cmd_vld`, and the pending byte is consumed the next cycle.
- Assert `rst` after A5,12 → all outputs return to reset values immediately; after release, a full frame decodes normally.
